// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit: opcodes, FSM states,
// ALU function selects and instruction field positions.
package control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    localparam logic [2:0] ALU_PASS_A = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 8;
    localparam int RB_MSB   = 7;
    localparam int RB_LSB   = 4;
    localparam int RQ_MSB   = 3;
    localparam int RQ_LSB   = 0;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and its datapath. The master side is the
// control unit: it consumes the instruction and drives every control line.
interface control_unit_if;
    logic [15:0] ir;
    logic        pc_clr;
    logic        pc_up;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s0;
    logic [3:0]  state_out;

    modport master (
        input  ir,
        output pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, state_out
    );

    modport slave (
        output ir,
        input  pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, state_out
    );
endinterface

// File: rtl/control_unit_instr_fields.sv
// Pure wiring: splits the 16-bit instruction word into its decode fields.
module instr_fields
    import control_unit_pkg::*;
(
    input  logic [15:0] ir_i,
    output opcode_e     opcode_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [3:0]  rq_o,
    output logic [7:0]  addr_o
);

    assign opcode_o = opcode_e'(ir_i[OPC_MSB:OPC_LSB]);
    assign ra_o     = ir_i[RA_MSB:RA_LSB];
    assign rb_o     = ir_i[RB_MSB:RB_LSB];
    assign rq_o     = ir_i[RQ_MSB:RQ_LSB];
    assign addr_o   = ir_i[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/control_unit.sv
// Moore-style sequencer for a small load/store CPU: fetch, decode, execute.
// Outputs depend only on the state register and the current instruction.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    state_e      state_q;
    state_e      state_d;
    opcode_e     opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rq;
    logic [7:0]  addr;

    logic        pc_clr;
    logic        pc_up;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s0;

    instr_fields u_fields (
        .ir_i     (bus.ir),
        .opcode_o (opcode),
        .ra_o     (ra),
        .rb_o     (rb),
        .rq_o     (rq),
        .addr_o   (addr)
    );

    // State register; reset lands in INIT even mid-instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs for the current state
    always_comb begin
        state_d    = state_q;
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = 8'd0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = 4'd0;
        rf_w_en    = 1'b0;
        rf_ra_addr = 4'd0;
        rf_rb_addr = 4'd0;
        alu_s0     = ALU_PASS_A;
        case (state_q)
            ST_INIT: begin
                pc_clr  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_ld   = 1'b1;
                pc_up   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Unassigned opcodes fall through to NOOP
                case (opcode)
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_NOOP: begin
                state_d = ST_FETCH;
            end
            ST_LOAD_A: begin
                d_addr    = addr;
                rf_s      = 1'b1;
                rf_w_addr = ra;
                state_d   = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                d_addr    = addr;
                rf_s      = 1'b1;
                rf_w_addr = ra;
                rf_w_en   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_STORE: begin
                d_addr     = addr;
                d_wr       = 1'b1;
                rf_ra_addr = ra;
                alu_s0     = ALU_PASS_A;
                state_d    = ST_FETCH;
            end
            ST_ADD: begin
                rf_ra_addr = ra;
                rf_rb_addr = rb;
                rf_w_addr  = rq;
                rf_w_en    = 1'b1;
                alu_s0     = ALU_ADD;
                state_d    = ST_FETCH;
            end
            ST_SUB: begin
                rf_ra_addr = ra;
                rf_rb_addr = rb;
                rf_w_addr  = rq;
                rf_w_en    = 1'b1;
                alu_s0     = ALU_SUB;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bus.pc_clr     = pc_clr;
    assign bus.pc_up      = pc_up;
    assign bus.ir_ld      = ir_ld;
    assign bus.d_addr     = d_addr;
    assign bus.d_wr       = d_wr;
    assign bus.rf_s       = rf_s;
    assign bus.rf_w_addr  = rf_w_addr;
    assign bus.rf_w_en    = rf_w_en;
    assign bus.rf_ra_addr = rf_ra_addr;
    assign bus.rf_rb_addr = rf_rb_addr;
    assign bus.alu_s0     = alu_s0;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: walks each instruction class cycle by cycle and compares
// the full output vector against hand-written expectations.
module tb_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic mon_en;
    logic we_seen;

    control_unit_if cu_if ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cu_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu}
    wire [32:0] obs = {cu_if.state_out, cu_if.pc_clr, cu_if.pc_up, cu_if.ir_ld,
                       cu_if.d_addr, cu_if.d_wr, cu_if.rf_s, cu_if.rf_w_addr,
                       cu_if.rf_w_en, cu_if.rf_ra_addr, cu_if.rf_rb_addr,
                       cu_if.alu_s0};

    always @(posedge clk or posedge cu_if.rf_w_en) begin
        if (mon_en && cu_if.rf_w_en) we_seen = 1'b1;
    end

    function automatic logic [32:0] ev(input logic [3:0] st, input logic pcc,
                                       input logic pcu, input logic irl,
                                       input logic [7:0] da, input logic dw,
                                       input logic rs, input logic [3:0] wa,
                                       input logic we, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [2:0] alu);
        return {st, pcc, pcu, irl, da, dw, rs, wa, we, ra, rb, alu};
    endfunction

    function automatic logic [32:0] e_init();
        return ev(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
    endfunction

    function automatic logic [32:0] e_fetch();
        return ev(4'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
    endfunction

    function automatic logic [32:0] e_idle(input logic [3:0] st);
        return ev(st, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
    endfunction

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%09h expected=%09h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [32:0] exp);
        @(negedge clk);
        check_eq(tag, obs, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        we_seen  = 1'b0;
        reset    = 1'b1;
        cu_if.ir = 16'h0000;

        repeat (2) @(negedge clk);
        check_eq("reset_init", obs, e_init());
        reset = 1'b0;
        #1 check_eq("init_hold", obs, e_init());
        cyc("fetch0", e_fetch());

        cu_if.ir = 16'h3123;
        cyc("add_decode", e_idle(4'd2));
        cyc("add_exec", ev(4'd7, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd1, 4'd2, 3'd1));
        cyc("add_fetch", e_fetch());

        cu_if.ir = 16'h4567;
        cyc("sub_decode", e_idle(4'd2));
        cyc("sub_exec", ev(4'd8, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd7, 1'b1, 4'd5, 4'd6, 3'd2));
        cyc("sub_fetch", e_fetch());

        cu_if.ir = 16'h2A1B;
        cyc("load_decode", e_idle(4'd2));
        cyc("load_a", ev(4'd4, 1'b0, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b1, 4'd10, 1'b0, 4'd0, 4'd0, 3'd0));
        cyc("load_b", ev(4'd5, 1'b0, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b1, 4'd10, 1'b1, 4'd0, 4'd0, 3'd0));
        cyc("load_fetch", e_fetch());

        cu_if.ir = 16'h1405;
        cyc("store_decode", e_idle(4'd2));
        cyc("store_exec", ev(4'd6, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 4'd0, 1'b0, 4'd4, 4'd0, 3'd0));
        cyc("store_fetch", e_fetch());

        cu_if.ir = 16'hF000;
        cyc("nopF_decode", e_idle(4'd2));
        cyc("nopF_exec", e_idle(4'd3));
        cyc("nopF_fetch", e_fetch());

        cu_if.ir = 16'h6000;
        cyc("nop6_decode", e_idle(4'd2));
        cyc("nop6_exec", e_idle(4'd3));
        cyc("nop6_fetch", e_fetch());

        cu_if.ir = 16'h0000;
        cyc("nop0_decode", e_idle(4'd2));
        cyc("nop0_exec", e_idle(4'd3));
        cyc("nop0_fetch", e_fetch());

        // Reset in the middle of a load must abort before the register write
        cu_if.ir = 16'h2A1B;
        cyc("abort_decode", e_idle(4'd2));
        mon_en  = 1'b1;
        cyc("abort_load_a", ev(4'd4, 1'b0, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b1, 4'd10, 1'b0, 4'd0, 4'd0, 3'd0));
        #2 reset = 1'b1;
        #1 check_eq("abort_init", obs, e_init());
        repeat (3) cyc("abort_hold", e_init());
        reset = 1'b0;
        #1 check_eq("abort_release", obs, e_init());
        cyc("abort_fetch", e_fetch());
        mon_en = 1'b0;
        check_eq("abort_no_we", {32'd0, we_seen}, 33'd0);

        cu_if.ir = 16'h5000;
        cyc("halt_decode", e_idle(4'd2));
        repeat (20) cyc("halt_hold", e_idle(4'd9));
        #2 reset = 1'b1;
        #1 check_eq("halt_reset", obs, e_init());
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("halt_release", obs, e_init());
        cyc("halt_fetch", e_fetch());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ir  input  16  current instruction from the instruction register.
REQ-004 SHALL have port: pc_clr  output  1  clear program counter to 0.
REQ-005 SHALL have port: pc_up  output  1  increment program counter by 1.
REQ-006 SHALL have port: ir_ld  output  1  load instruction register from instruction memory.
REQ-007 SHALL have port: d_addr  output  8  data memory address.
REQ-008 SHALL have port: d_wr  output  1  data memory write enable.
REQ-009 SHALL have port: rf_s  output  1  register-file write mux: 1 = data memory, 0 = ALU.
REQ-010 SHALL have port: rf_w_addr  output  4  register-file write address.
REQ-011 SHALL have port: rf_w_en  output  1  register-file write enable.
REQ-012 SHALL have port: rf_ra_addr  output  4  register-file read port A address.
REQ-013 SHALL have port: rf_rb_addr  output  4  register-file read port B address.
REQ-014 SHALL have port: alu_s0  output  3  ALU function select: 0 pass A, 1 add, 2 sub.
REQ-015 SHALL have port: state_out  output  4  current state encoding, for debug display.
REQ-016 SHALL have default: every output not named for a state SHALL be 0 in that state.

Function
REQ-017 SHALL decode the instruction fields as follows:
- opcode = ir[15:12]
- ra = ir[11:8]
- rb = ir[7:4]
- rq = ir[3:0]
- addr = ir[7:0]
REQ-018 SHALL use these opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT; opcodes 6-15 SHALL execute as NOOP.
REQ-019 SHALL be a Moore machine; outputs SHALL be a combinational function of the state register and ir only.
REQ-020 SHALL have states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-021 INIT: pc_clr=1; next state FETCH.
REQ-022 FETCH: ir_ld=1, pc_up=1; next state DECODE. The new ir is valid from DECODE onward.
REQ-023 DECODE: no outputs asserted; next state selected by opcode per REQ-018.
REQ-024 NOOP: no outputs asserted; next state FETCH.
REQ-025 LOAD_A: d_addr=addr, rf_s=1, rf_w_addr=ra; next state LOAD_B. This cycle absorbs the one-cycle memory read latency.
REQ-026 LOAD_B: d_addr=addr, rf_s=1, rf_w_addr=ra, rf_w_en=1; next state FETCH.
REQ-027 STORE: d_addr=addr, d_wr=1, rf_ra_addr=ra, alu_s0=0; next state FETCH.
REQ-028 ADD: rf_ra_addr=ra, rf_rb_addr=rb, rf_w_addr=rq, rf_w_en=1, rf_s=0, alu_s0=1; next state FETCH.
REQ-029 SUB: identical to ADD except alu_s0=2; next state FETCH.
REQ-030 HALT: no outputs asserted; remains in HALT until reset.
REQ-031 Instruction latency SHALL be:
- NOOP, STORE, ADD, SUB: 3 cycles (FETCH, DECODE, execute).
- LOAD: 4 cycles.
REQ-032 Writes SHALL be single-cycle: rf_w_en and d_wr SHALL each be high for exactly one cycle per instruction.
REQ-033 PC wrap-around is the program counter's responsibility; this block SHALL assert pc_up exactly once per instruction regardless of PC value.

Reset
REQ-034 Asserting reset SHALL force state INIT immediately, in any state including mid-LOAD; outputs SHALL take INIT values (pc_clr=1, all others 0).
REQ-035 After reset deasserts, INIT SHALL last exactly one clock before FETCH.
REQ-036 HALT SHALL be exited only by reset.

Structure
REQ-037 A shared package SHALL hold:
- the opcode enum (4-bit)
- the state enum (4-bit, values 0-9 in the REQ-020 order)
- ALU select constants
- instruction field position constants
REQ-038 A single sub-module, instr_fields, SHALL split ir into opcode, ra, rb, rq and addr; the rest SHALL be one state register plus next-state and output logic.

Verification
REQ-039 Reset pulse, then release -> state_out=INIT with pc_clr=1 for one cycle, then FETCH with ir_ld=1 and pc_up=1.
REQ-040 ir=16'h3123 -> in ADD: rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=3, rf_w_en=1, alu_s0=1; back to FETCH 3 cycles after the start of FETCH.
REQ-041 ir=16'h2A1B -> LOAD_A then LOAD_B with d_addr=8'h1B, rf_s=1, rf_w_addr=10; rf_w_en high only in LOAD_B.
REQ-042 ir=16'h1405 -> STORE: d_addr=8'h05, d_wr=1, rf_ra_addr=4 for exactly one cycle.
REQ-043 ir=16'h5000 -> HALT held for 20 cycles, no pc_up; reset asserted -> INIT.
REQ-044 ir=16'hF000 -> NOOP path, then FETCH; reset asserted during LOAD_A -> INIT with rf_w_en never asserted.
